// File: rtl/run_decoder.sv
// JPEG-LS run-mode decoder: consumes the serial run bitstream one bit per handshake
// and rebuilds the run length, updated RUNindex and end-of-line/interruption status.
module run_decoder #(
    parameter int runcount_length = 16,
    parameter int runindex_length = 5,
    parameter int J_length        = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start_dec,
    input  logic [runindex_length-1:0] run_index_in,
    input  logic [runcount_length-1:0] pixels_remaining,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    output logic                       bit_ready,
    output logic [runcount_length-1:0] run_length,
    output logic [runindex_length-1:0] run_index_new,
    output logic [J_length-1:0]        J,
    output logic                       eol,
    output logic                       err,
    output logic                       done
);

    typedef enum logic [1:0] {IDLE, READ_FLAG, READ_REM, DONE} state_t;

    // J[RUNindex]: 0 for 0..3, then steps of 1 every 4, every 2, then every entry.
    function automatic logic [J_length-1:0] j_of(input logic [runindex_length-1:0] i);
        int unsigned v;
        v = 32'(i);
        if (v < 16)      return J_length'(v >> 2);
        else if (v < 24) return J_length'(4 + ((v - 16) >> 1));
        else             return J_length'(v - 16);
    endfunction

    state_t                       state;
    logic [runcount_length-1:0]   accum;
    logic [runcount_length-1:0]   rem;
    logic [runcount_length-1:0]   remainder;
    logic [runindex_length-1:0]   idx;
    logic [J_length-1:0]          bit_cnt;

    logic [J_length-1:0]          j_cur;
    logic [runcount_length:0]     rg;
    logic [runcount_length:0]     flag_sum;
    logic [runcount_length-1:0]   rem_next;
    logic [runcount_length:0]     rem_sum;
    logic [runindex_length-1:0]   idx_inc;
    logic [runindex_length-1:0]   idx_dec;
    logic                         xfer;

    always_comb begin
        j_cur    = j_of(idx);
        rg       = (runcount_length + 1)'(1) << j_cur;
        flag_sum = {1'b0, accum} + rg;
        rem_next = {remainder[runcount_length-2:0], bit_in};
        rem_sum  = {1'b0, accum} + {1'b0, rem_next};
        idx_inc  = (idx == '1) ? idx : idx + 1'b1;
        idx_dec  = (idx == '0) ? idx : idx - 1'b1;
        xfer     = bit_valid && bit_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            accum         <= '0;
            rem           <= '0;
            remainder     <= '0;
            idx           <= '0;
            bit_cnt       <= '0;
            bit_ready     <= 1'b0;
            run_length    <= '0;
            run_index_new <= '0;
            J             <= '0;
            eol           <= 1'b0;
            err           <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_dec) begin
                        idx   <= run_index_in;
                        rem   <= pixels_remaining;
                        accum <= '0;
                        eol   <= 1'b0;
                        err   <= 1'b0;
                        if (pixels_remaining == '0) begin
                            state         <= DONE;
                            done          <= 1'b1;
                            eol           <= 1'b1;
                            run_length    <= '0;
                            run_index_new <= run_index_in;
                            J             <= j_of(run_index_in);
                        end else begin
                            state     <= READ_FLAG;
                            bit_ready <= 1'b1;
                        end
                    end
                end
                READ_FLAG: begin
                    if (xfer) begin
                        if (bit_in) begin
                            if (flag_sum <= {1'b0, rem}) begin
                                accum <= flag_sum[runcount_length-1:0];
                                idx   <= idx_inc;
                                if (flag_sum[runcount_length-1:0] == rem) begin
                                    state         <= DONE;
                                    done          <= 1'b1;
                                    bit_ready     <= 1'b0;
                                    eol           <= 1'b1;
                                    run_length    <= rem;
                                    run_index_new <= idx_inc;
                                    J             <= j_cur;
                                end
                            end else begin
                                // Overshoot past the line end: run is truncated to the line.
                                accum         <= rem;
                                state         <= DONE;
                                done          <= 1'b1;
                                bit_ready     <= 1'b0;
                                eol           <= 1'b1;
                                run_length    <= rem;
                                run_index_new <= idx;
                                J             <= j_cur;
                            end
                        end else if (j_cur == '0) begin
                            state         <= DONE;
                            done          <= 1'b1;
                            bit_ready     <= 1'b0;
                            run_length    <= accum;
                            run_index_new <= idx_dec;
                            J             <= j_cur;
                        end else begin
                            bit_cnt   <= j_cur;
                            remainder <= '0;
                            state     <= READ_REM;
                        end
                    end
                end
                READ_REM: begin
                    if (xfer) begin
                        remainder <= rem_next;
                        bit_cnt   <= bit_cnt - 1'b1;
                        if (bit_cnt == J_length'(1)) begin
                            state         <= DONE;
                            done          <= 1'b1;
                            bit_ready     <= 1'b0;
                            run_index_new <= idx_dec;
                            J             <= j_cur;
                            if (rem_sum >= {1'b0, rem}) begin
                                err        <= 1'b1;
                                accum      <= rem - 1'b1;
                                run_length <= rem - 1'b1;
                            end else begin
                                accum      <= rem_sum[runcount_length-1:0];
                                run_length <= rem_sum[runcount_length-1:0];
                            end
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_run_decoder.sv
// Scoreboard bench for run_decoder: stimulus pushes expected results, a negedge
// monitor pops and compares them whenever done is presented.
module tb_run_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_dec;
    logic [4:0]  run_index_in;
    logic [15:0] pixels_remaining;
    logic        bit_in;
    logic        bit_valid;
    logic        bit_ready;
    logic [15:0] run_length;
    logic [4:0]  run_index_new;
    logic [3:0]  J;
    logic        eol;
    logic        err;
    logic        done;

    run_decoder #(
        .runcount_length(16),
        .runindex_length(5),
        .J_length(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_dec(start_dec),
        .run_index_in(run_index_in),
        .pixels_remaining(pixels_remaining),
        .bit_in(bit_in),
        .bit_valid(bit_valid),
        .bit_ready(bit_ready),
        .run_length(run_length),
        .run_index_new(run_index_new),
        .J(J),
        .eol(eol),
        .err(err),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rl;
        int idx_new;
        int j;
        int eol;
        int err;
        int nbits;
    } exp_t;

    int jtab[32] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,4,4,5,5,6,6,7,7,8,9,10,11,12,13,14,15};

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: walks the run-mode rules over the bit array with integers.
    function automatic exp_t model(input int idx, input int rem, input logic [63:0] bits);
        exp_t e;
        int acc = 0;
        int k = 0;
        int j;
        int r;
        e = '{default: 0};
        if (rem == 0) begin
            e.eol = 1; e.idx_new = idx; e.j = jtab[idx];
            return e;
        end
        forever begin
            j = jtab[idx];
            e.j = j;
            if (bits[k] == 1'b1) begin
                k++;
                if (acc + (1 << j) <= rem) begin
                    acc += 1 << j;
                    if (idx < 31) idx++;
                    if (acc == rem) begin e.eol = 1; e.idx_new = idx; break; end
                end else begin
                    acc = rem; e.eol = 1; e.idx_new = idx; break;
                end
            end else begin
                k++;
                r = 0;
                for (int i = 0; i < j; i++) begin r = r * 2 + int'(bits[k]); k++; end
                acc += r;
                if (acc >= rem) begin e.err = 1; acc = rem - 1; end
                e.idx_new = (idx > 0) ? idx - 1 : 0;
                break;
            end
        end
        e.rl = acc;
        e.nbits = k;
        return e;
    endfunction

    // Monitor: inputs are driven at posedge+1, so negedge sees them stable.
    int hs_cnt = 0;
    bit prev_hs = 0;
    bit prev_start = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            hs_cnt = 0; prev_hs = 0; prev_start = 0;
        end else begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("run_length", 32'(run_length), e.rl);
                    check("run_index_new", 32'(run_index_new), e.idx_new);
                    check("J", 32'(J), e.j);
                    check("eol", 32'(eol), e.eol);
                    check("err", 32'(err), e.err);
                    check("handshakes", hs_cnt, e.nbits);
                    check("latency", 32'(e.nbits == 0 ? prev_start : prev_hs), 32'd1);
                    check("bit_ready_at_done", 32'(bit_ready), 32'd0);
                end
            end
            prev_hs    = bit_valid && bit_ready;
            prev_start = start_dec;
            if (start_dec) hs_cnt = 0;
            else if (prev_hs) hs_cnt++;
        end
    end

    task automatic check_cleared(input string name);
        check(name, {run_length, run_index_new, J, eol, err, done, bit_ready}, 32'd0);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #1;
        reset = 1'b0; start_dec = 1'b0; bit_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        check_cleared("reset_state");
        reset = 1'b1;
    endtask

    // Issue one run and feed bits as the DUT accepts them; stall_at >= 0 drops
    // bit_valid for 5 cycles once that many bits have been consumed.
    task automatic run_case(input int idx, input int rem, input logic [63:0] bits,
                            input exp_t e, input int stall_at);
        int k = 0;
        int cyc = 0;
        int stall = 0;
        @(posedge clk); #1;
        start_dec = 1'b1;
        run_index_in = 5'(idx);
        pixels_remaining = 16'(rem);
        bit_valid = 1'b0;
        exp_q.push_back(e);
        forever begin
            @(posedge clk); #1;
            start_dec = 1'b0;
            if (done) break;
            if (++cyc > 400) begin
                check("timeout", 32'd1, 32'd0);
                void'(exp_q.pop_back());
                do_reset(2);
                break;
            end
            if (k == stall_at && stall < 5) begin
                bit_valid = 1'b0;
                stall++;
                if (stall == 5) begin
                    check("stall_ready_held", 32'(bit_ready), 32'd1);
                    check("stall_no_done", 32'(done), 32'd0);
                end
            end else begin
                bit_valid = ($urandom_range(3) != 0);
                bit_in = (k < 64) ? bits[k] : 1'b0;
                if (bit_valid && bit_ready) k++;
            end
        end
        bit_valid = 1'b0;
    endtask

    function automatic exp_t mk(input int rl, input int idx_new, input int j,
                                input int eol_v, input int err_v, input int nbits);
        exp_t e;
        e.rl = rl; e.idx_new = idx_new; e.j = j; e.eol = eol_v; e.err = err_v; e.nbits = nbits;
        return e;
    endfunction

    initial begin
        logic [63:0] bits;
        exp_t e;
        int   idx;
        int   rem;
        reset = 1'b0; start_dec = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        run_index_in = '0; pixels_remaining = '0;
        do_reset(3);

        // Directed cases (bits listed LSB-first: bits[0] is the first bit sent).
        bits = 64'b0111;  run_case(0, 10, bits, mk(3, 2, 0, 0, 0, 4), -1);
        bits = 64'b101;   run_case(4, 20, bits, mk(3, 4, 1, 0, 0, 3), -1);
        bits = 64'b11;    run_case(0, 2, bits, mk(2, 2, 0, 1, 0, 2), -1);
        bits = 64'b1;     run_case(12, 5, bits, mk(5, 12, 3, 1, 0, 1), -1);
        bits = 64'b110;   run_case(8, 3, bits, mk(2, 7, 2, 0, 1, 3), -1);
        bits = 64'b0;     run_case(9, 0, bits, mk(0, 9, 2, 1, 0, 0), -1);
        bits = 64'b010;   run_case(8, 100, bits, mk(2, 7, 2, 0, 0, 3), 2);

        // Reset in the middle of READ_REM discards the partial run.
        @(posedge clk); #1;
        start_dec = 1'b1; run_index_in = 5'd8; pixels_remaining = 16'd100;
        @(posedge clk); #1;
        start_dec = 1'b0; bit_valid = 1'b1; bit_in = 1'b0;
        @(posedge clk); #1;
        bit_in = 1'b1;
        @(posedge clk); #1;
        bit_valid = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
        check_cleared("mid_run_reset");
        reset = 1'b1;
        bits = 64'b0111;  run_case(0, 10, bits, mk(3, 2, 0, 0, 0, 4), -1);

        // Randomized runs checked against the model.
        for (int n = 0; n < 60; n++) begin
            idx = $urandom_range(31);
            case ($urandom_range(7))
                0:       rem = 0;
                1, 2, 3: rem = $urandom_range(40, 1);
                4, 5:    rem = $urandom_range(2000, 1);
                default: rem = $urandom_range(65535, 1);
            endcase
            bits = {$urandom, $urandom};
            e = model(idx, rem, bits);
            run_case(idx, rem, bits, e, -1);
        end

        repeat (3) @(posedge clk);
        #1;
        check("pending_expected", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
